// File: rtl/ngp_pkg.sv
// ============================================================================
// Module : ngp_pkg
// Shared types and field positions for the nandgameplus decode path.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ngp_pkg;

  localparam int NGP_DATA_W = 16;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_XOR = 3'b010,
    ALU_NOT = 3'b011,
    ALU_ADD = 3'b100,
    ALU_SUB = 3'b101,
    ALU_INC = 3'b110,
    ALU_DEC = 3'b111
  } alu_op_e;

  // Bit positions inside the {A, D, *A} and {lt, eq, gt} fields
  localparam int DEST_A = 2;
  localparam int DEST_D = 1;
  localparam int DEST_M = 0;
  localparam int JMP_LT = 2;
  localparam int JMP_EQ = 1;
  localparam int JMP_GT = 0;

  localparam int INSTR_CI  = 15;
  localparam int RSV_HI    = 14;
  localparam int OP_MSB    = 13;
  localparam int OP_LSB    = 11;
  localparam int ZY_BIT    = 10;
  localparam int SW_BIT    = 9;
  localparam int DEST_MSB  = 8;
  localparam int DEST_LSB  = 6;
  localparam int RSV_MSB   = 5;
  localparam int RSV_LSB   = 3;
  localparam int JMP_MSB   = 2;
  localparam int JMP_LSB   = 0;
  localparam int IMM_MSB   = 14;

  typedef struct packed {
    alu_op_e                 op;
    logic                    zy;
    logic                    sw;
    logic [2:0]              dest;
    logic [2:0]              jmp;
    logic                    is_imm;
    logic [NGP_DATA_W-1:0]   imm;
    logic                    illegal;
  } ngp_ctrl_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

endpackage

`default_nettype wire

// File: rtl/ngp_skid_buf.sv
// ============================================================================
// Module : ngp_skid_buf
// Two-entry valid/ready skid buffer; ready depends on occupancy only.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ngp_skid_buf
  import ngp_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  skid_state_e  r_state;
  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic         w_accept;
  logic         w_pop;

  assign o_ready  = (r_state != SKID_TWO);
  assign o_valid  = (r_state != SKID_EMPTY);
  assign o_data   = r_head;
  assign w_accept = i_valid & o_ready;
  assign w_pop    = o_valid & i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SKID_EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else if (i_flush) begin
      r_state <= SKID_EMPTY;
    end else begin
      case (r_state)
        SKID_EMPTY: begin
          if (w_accept) begin
            r_head  <= i_data;
            r_state <= SKID_ONE;
          end
        end
        SKID_ONE: begin
          // Simultaneous pop and accept keeps occupancy at one: new entry becomes head
          if (w_accept && w_pop) begin
            r_head <= i_data;
          end else if (w_accept) begin
            r_tail  <= i_data;
            r_state <= SKID_TWO;
          end else if (w_pop) begin
            r_state <= SKID_EMPTY;
          end
        end
        SKID_TWO: begin
          if (w_pop) begin
            r_head  <= r_tail;
            r_state <= SKID_ONE;
          end
        end
        default: r_state <= SKID_EMPTY;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ngp_decode_stage.sv
// ============================================================================
// Module : ngp_decode_stage
// Instruction decode feeding the ALU control bundle through a skid buffer.
// Optional: NGP_DECODE_ILLEGAL_EN adds reserved-bit checking and out_illegal.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ngp_decode_stage
  import ngp_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int IMM_SIGN_EXT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_op,
  output logic              out_zy,
  output logic              out_sw,
  output logic [2:0]        out_dest,
  output logic [2:0]        out_jmp,
  output logic              out_is_imm,
  output logic [DATA_W-1:0] out_imm
`ifdef NGP_DECODE_ILLEGAL_EN
  ,
  output logic              out_illegal
`endif
);

  localparam int CTRL_W = $bits(ngp_ctrl_t);

  ngp_ctrl_t         w_dec;
  ngp_ctrl_t         w_head;
  logic [CTRL_W-1:0] w_head_bits;
  logic              w_unused;

  always_comb begin
    w_dec = '0;
    if (in_instr[INSTR_CI]) begin
      w_dec.op   = alu_op_e'(in_instr[OP_MSB:OP_LSB]);
      w_dec.zy   = in_instr[ZY_BIT];
      w_dec.sw   = in_instr[SW_BIT];
      w_dec.dest = in_instr[DEST_MSB:DEST_LSB];
      w_dec.jmp  = in_instr[JMP_MSB:JMP_LSB];
`ifdef NGP_DECODE_ILLEGAL_EN
      // Reserved bits set: squash side effects but keep the slot so order is preserved
      if (in_instr[RSV_HI] || (in_instr[RSV_MSB:RSV_LSB] != 3'b000)) begin
        w_dec.op      = ALU_AND;
        w_dec.dest    = 3'b000;
        w_dec.jmp     = 3'b000;
        w_dec.illegal = 1'b1;
      end
`endif
    end else begin
      w_dec.is_imm       = 1'b1;
      w_dec.dest[DEST_A] = 1'b1;
      w_dec.imm          = (IMM_SIGN_EXT != 0) ? {in_instr[IMM_MSB], in_instr[IMM_MSB:0]}
                                               : {1'b0, in_instr[IMM_MSB:0]};
    end
  end

  ngp_skid_buf #(
    .W (CTRL_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_dec),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_head_bits)
  );

  assign w_head     = ngp_ctrl_t'(w_head_bits);
  assign out_op     = w_head.op;
  assign out_zy     = w_head.zy;
  assign out_sw     = w_head.sw;
  assign out_dest   = w_head.dest;
  assign out_jmp    = w_head.jmp;
  assign out_is_imm = w_head.is_imm;
  assign out_imm    = w_head.imm;

`ifdef NGP_DECODE_ILLEGAL_EN
  assign out_illegal = w_head.illegal;
  assign w_unused    = 1'b0;
`else
  assign w_unused    = ^{w_head.illegal, in_instr[RSV_MSB:RSV_LSB]};
`endif

endmodule

`default_nettype wire

// File: tb/tb_ngp_decode_stage.sv
// ============================================================================
// Module : tb_ngp_decode_stage
// Directed self-checking bench for ngp_decode_stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ngp_decode_stage;

  localparam int DATA_W       = 16;
  localparam int IMM_SIGN_EXT = 0;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_instr;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        out_op;
  logic              out_zy;
  logic              out_sw;
  logic [2:0]        out_dest;
  logic [2:0]        out_jmp;
  logic              out_is_imm;
  logic [DATA_W-1:0] out_imm;
`ifdef NGP_DECODE_ILLEGAL_EN
  logic              out_illegal;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ngp_decode_stage #(
    .DATA_W       (DATA_W),
    .IMM_SIGN_EXT (IMM_SIGN_EXT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_op     (out_op),
    .out_zy     (out_zy),
    .out_sw     (out_sw),
    .out_dest   (out_dest),
    .out_jmp    (out_jmp),
    .out_is_imm (out_is_imm),
    .out_imm    (out_imm)
`ifdef NGP_DECODE_ILLEGAL_EN
    ,
    .out_illegal (out_illegal)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    tick(); tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if ({out_op, out_zy, out_sw, out_dest, out_jmp, out_is_imm} !== 12'h000)
      begin n_fail++; $display("FAIL reset_ctrl: got %h want 000", {out_op, out_zy, out_sw, out_dest, out_jmp, out_is_imm}); end
    n_checks++; if (out_imm !== 16'h0000) begin n_fail++; $display("FAIL reset_imm: got %h want 0000", out_imm); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_compute();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 16'hA080;
    tick();
    in_instr = 16'hBFC7;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b want 1", out_valid); end
    n_checks++; if ({out_op, out_zy, out_sw, out_dest, out_jmp, out_is_imm} !== {3'b100, 1'b0, 1'b0, 3'b010, 3'b000, 1'b0})
      begin n_fail++; $display("FAIL add_ctrl: got %b want 100_0_0_010_000_0", {out_op, out_zy, out_sw, out_dest, out_jmp, out_is_imm}); end
    n_checks++; if (out_imm !== 16'h0000) begin n_fail++; $display("FAIL add_imm: got %h want 0000", out_imm); end
    tick();
    in_valid = 1'b0;
    n_checks++; if ({out_valid, out_op, out_zy, out_sw, out_dest, out_jmp, out_is_imm} !== {1'b1, 3'b111, 1'b1, 1'b1, 3'b111, 3'b111, 1'b0})
      begin n_fail++; $display("FAIL dec_ctrl: got %b want 1_111_1_1_111_111_0", {out_valid, out_op, out_zy, out_sw, out_dest, out_jmp, out_is_imm}); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL compute_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_load();
    logic [15:0] exp7;
    exp7 = (IMM_SIGN_EXT != 0) ? 16'hFFFF : 16'h7FFF;
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 16'h1234;
    tick();
    in_instr = 16'h7FFF;
    n_checks++; if ({out_valid, out_is_imm, out_dest, out_op, out_jmp} !== {1'b1, 1'b1, 3'b100, 3'b000, 3'b000})
      begin n_fail++; $display("FAIL load_ctrl: got %b want 1_1_100_000_000", {out_valid, out_is_imm, out_dest, out_op, out_jmp}); end
    n_checks++; if (out_imm !== 16'h1234) begin n_fail++; $display("FAIL load_imm_1234: got %h want 1234", out_imm); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_imm !== exp7) begin n_fail++; $display("FAIL load_imm_7fff: got %h want %h", out_imm, exp7); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [15:0] got [$];
    logic        acc;
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h0001;
    tick();
    in_instr = 16'h0002;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_one: got %b want 1", in_ready); end
    tick();
    in_instr = 16'h0003;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_two: got %b want 0", in_ready); end
    n_checks++; if (out_imm !== 16'h0001) begin n_fail++; $display("FAIL bp_head: got %h want 0001", out_imm); end
    tick();
    n_checks++; if ({in_ready, out_valid, out_imm} !== {1'b0, 1'b1, 16'h0001})
      begin n_fail++; $display("FAIL bp_hold: got %b_%b_%h want 0_1_0001", in_ready, out_valid, out_imm); end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) got.push_back(out_imm);
      acc = in_valid && in_ready;
      tick();
      if (acc) in_valid = 1'b0;
    end
    n_checks++; if (got.size() != 3) begin n_fail++; $display("FAIL bp_count: got %0d want 3", got.size()); end
    for (int i = 0; i < got.size() && i < 3; i++) begin
      n_checks++; if (got[i] !== 16'(i + 1)) begin n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], 16'(i + 1)); end
    end
  endtask

  task automatic test_streaming();
    logic [15:0] got [$];
    int          drops = 0;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_instr = 16'h0010 + 16'(i);
      if (i == 8) in_valid = 1'b0;
      if (!in_ready) drops++;
      if (out_valid) got.push_back(out_imm);
      tick();
    end
    if (out_valid) got.push_back(out_imm);
    tick();
    n_checks++; if (drops != 0) begin n_fail++; $display("FAIL stream_ready_drops: got %0d want 0", drops); end
    n_checks++; if (got.size() != 8) begin n_fail++; $display("FAIL stream_count: got %0d want 8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      n_checks++; if (got[i] !== 16'h0010 + 16'(i)) begin n_fail++; $display("FAIL stream_order[%0d]: got %h want %h", i, got[i], 16'h0010 + 16'(i)); end
    end
  endtask

  task automatic test_flush();
    int seen = 0;
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h0100;
    tick();
    in_instr = 16'h0101;
    tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_pre_two: got %b want 0", in_ready); end
    in_instr = 16'h0102; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL flush_two: got %b want 01", {out_valid, in_ready}); end
    // flush from ONE while an accept is offered: the offered word must vanish
    in_valid = 1'b1; in_instr = 16'h0200;
    tick();
    in_instr = 16'h0155; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) seen++;
      tick();
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL flush_one_drop: got %0d outputs want 0", seen); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h0200;
    tick();
    in_valid = 1'b0;
    n_checks++; if ({out_valid, out_imm} !== {1'b1, 16'h0200}) begin n_fail++; $display("FAIL arst_pre: got %b_%h want 1_0200", out_valid, out_imm); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({out_valid, in_ready, out_imm} !== {1'b0, 1'b1, 16'h0000})
      begin n_fail++; $display("FAIL arst_immediate: got %b_%b_%h want 0_1_0000", out_valid, in_ready, out_imm); end
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_no_replay: got %b want 0", out_valid); end
  endtask

  task automatic test_reserved();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 16'hC0C0;
    tick();
    in_valid = 1'b0;
`ifdef NGP_DECODE_ILLEGAL_EN
    n_checks++; if ({out_valid, out_illegal, out_dest, out_jmp, out_op} !== {1'b1, 1'b1, 3'b000, 3'b000, 3'b000})
      begin n_fail++; $display("FAIL illegal_nop: got %b want 1_1_000_000_000", {out_valid, out_illegal, out_dest, out_jmp, out_op}); end
    in_valid = 1'b1; in_instr = 16'hA080;
    tick();
    in_valid = 1'b0;
    n_checks++; if ({out_illegal, out_dest} !== {1'b0, 3'b010}) begin n_fail++; $display("FAIL illegal_clear: got %b want 0_010", {out_illegal, out_dest}); end
`else
    n_checks++; if ({out_valid, out_dest, out_jmp, out_op} !== {1'b1, 3'b011, 3'b000, 3'b000})
      begin n_fail++; $display("FAIL reserved_ignored: got %b want 1_011_000_000", {out_valid, out_dest, out_jmp, out_op}); end
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_compute();
    test_load();
    test_backpressure();
    test_streaming();
    test_flush();
    test_reserved();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
